muldiv_unit: RTL

- Parametrised iterative multiply/divide engine that produces the HI/LO pair for the multi-cycle datapath.
- It replaces the separate fixed 32-bit mult and div blocks with one shared shift/add-subtract datapath.
- The control unit issues a one-cycle start and stalls on busy. The engine returns done, with div_zero for the exception path.
- Supports signed and unsigned operation at any even WIDTH.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a single sign-correction cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W = WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic [W:0]       psum;
  logic [W:0]       rshift;
  logic [W-1:0]     rdiff;
  logic             qbit;
  logic [2*W-1:0]   prod_fix;

  // Multiply: a_q is the LSB-first multiplier, b_q the multiplicand; the
  // W+1-bit partial sum shifts into the top of the accumulator each step.
  // Divide: a_q feeds dividend bits MSB-first into the partial remainder held
  // in acc_q[2W-1:W]; quotient bits shift into acc_q[W-1:0].
  always_comb begin
    psum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q & {W{a_q[0]}}};
    rshift   = {acc_q[2*W-1:W], a_q[W-1]};
    qbit     = (rshift >= {1'b0, b_q});
    // True difference is below b_q when qbit is set, so W bits suffice.
    rdiff    = rshift[W-1:0] - b_q;
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sgn_d   = is_signed;
          a_d     = op_a;
          b_d     = op_b;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        neg_a_d = sgn_q & a_q[W-1];
        neg_b_d = sgn_q & b_q[W-1];
        a_d     = (sgn_q && a_q[W-1]) ? -a_q : a_q;
        b_d     = (sgn_q && b_q[W-1]) ? -b_q : b_q;
        if (op_q && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_q) begin
          acc_d = {psum, acc_q[W-1:1]};
          a_d   = a_q >> 1;
        end else begin
          acc_d = {(qbit ? rdiff : rshift[W-1:0]), acc_q[W-2:0], qbit};
          a_d   = a_q << 1;
        end
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (!op_q) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else begin
          lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
          hi_d = neg_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
